// File: rtl/ex_alu_mc.sv
// ex_alu_mc -- single-issue execute ALU with an optional iterative multiplier.
// Ops other than MUL complete with latency 1 and never stall.
// Build option: define EX_ALU_MUL_EN to implement MUL (aluop 11) as a
// shift-add multiplier retiring MUL_STEPS multiplier bits per BUSY cycle.
// Without it, aluop 11 behaves like a reserved code and in_ready is tied high.
// Handshake: a request transfers on a rising edge where in_valid && in_ready
// (and no flush); operands/aluop are sampled only on that edge. out_valid is a
// one-cycle pulse marking the cycle in which a freshly registered result appears.
module ex_alu_mc #(
    parameter int XLEN      = 32,
    parameter int MUL_STEPS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [XLEN-1:0] imme,
    input  logic            alusrc,
    input  logic [3:0]      aluop,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;

    logic [XLEN-1:0] w_op2;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_alu;
    logic            w_accept;

    assign w_op2    = alusrc ? imme : op_b;
    assign w_shamt  = w_op2[SHW-1:0];
    assign w_accept = in_valid && in_ready && !flush;
    assign zero     = (result == '0);

    // Single-cycle datapath; NONE and every unlisted code yield zero.
    always_comb begin
        w_alu = '0;
        case (aluop)
            OP_ADD:  w_alu = op_a + w_op2;
            OP_SUB:  w_alu = op_a - w_op2;
            OP_AND:  w_alu = op_a & w_op2;
            OP_OR:   w_alu = op_a | w_op2;
            OP_XOR:  w_alu = op_a ^ w_op2;
            OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(w_op2))};
            OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (op_a < w_op2)};
            OP_SLL:  w_alu = op_a << w_shamt;
            OP_SRL:  w_alu = op_a >> w_shamt;
            OP_SRA:  w_alu = $unsigned($signed(op_a) >>> w_shamt);
            default: w_alu = '0;
        endcase
    end

`ifdef EX_ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd11;
    localparam int         N_ITER = XLEN / MUL_STEPS;
    localparam int         CW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [XLEN-1:0] r_acc;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] w_partial;

    assign in_ready = (r_state == S_IDLE);

    // Sum of the shifted multiplicand copies selected by the low MUL_STEPS multiplier bits.
    always_comb begin
        w_partial = '0;
        for (int j = 0; j < MUL_STEPS; j++) begin
            if (r_mplier[j]) w_partial = w_partial + (r_mcand << j);
        end
    end

    // IDLE/BUSY controller, multiplier iteration and registered result/out_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    if (aluop == OP_MUL) begin
                        r_state  <= S_BUSY;
                        r_mcand  <= op_a;
                        r_mplier <= w_op2;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end else begin
                        result    <= w_alu;
                        out_valid <= 1'b1;
                    end
                end
            end else if (flush) begin
                // Abort: partial product dropped, result left as it was.
                r_state  <= S_IDLE;
                r_mcand  <= '0;
                r_mplier <= '0;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else begin
                r_acc    <= r_acc + w_partial;
                r_mcand  <= r_mcand << MUL_STEPS;
                r_mplier <= r_mplier >> MUL_STEPS;
                r_cnt    <= r_cnt + 1'b1;
                if (r_cnt == CW'(N_ITER - 1)) begin
                    r_state   <= S_IDLE;
                    result    <= r_acc + w_partial;
                    out_valid <= 1'b1;
                end
            end
        end
    end
`else
    assign in_ready = 1'b1;

    // Every accepted op completes on the following edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= w_accept;
            if (w_accept) result <= w_alu;
        end
    end
`endif

endmodule

// File: tb/tb_ex_alu_mc.sv
// Directed bench for ex_alu_mc (XLEN=32, MUL_STEPS=1). Multiplier scenarios are
// compiled in only when EX_ALU_MUL_EN is defined, matching the DUT build.
module tb_ex_alu_mc;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] imme;
  logic            alusrc;
  logic [3:0]      aluop;
  logic            flush;
  logic            out_valid;
  logic [XLEN-1:0] result;
  logic            zero;

  int checks   = 0;
  int failures = 0;

  ex_alu_mc #(.XLEN(XLEN), .MUL_STEPS(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .imme(imme), .alusrc(alusrc), .aluop(aluop),
    .flush(flush), .out_valid(out_valid), .result(result), .zero(zero)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present one request for exactly one edge, then withdraw it
  task automatic issue(input logic [3:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] imm,
                       input logic src);
    aluop = op; op_a = a; op_b = b; imme = imm; alusrc = src;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    bit seen_ov;
    reset = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; imme = '0;
    alusrc = 1'b0; aluop = 4'd0; flush = 1'b0;
    #2;
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    step();
    reset = 1'b0;

    // ADD wraps to zero; out_valid exactly one cycle
    issue(4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    check("add_wrap_result", result, 32'h0);
    check("add_wrap_zero", zero, 1);
    check("add_wrap_ov", out_valid, 1);
    step();
    check("add_wrap_ov_drop", out_valid, 0);

    issue(4'd1, 32'd5, 32'd7, 32'h0, 1'b0);
    check("sub_result", result, 32'hFFFF_FFFE);
    check("sub_zero", zero, 0);
    issue(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 1'b0);
    check("and_result", result, 32'h00F0_1200);
    issue(4'd3, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 1'b0);
    check("or_result", result, 32'hFFF0_FF34);
    issue(4'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 1'b0);
    check("xor_result", result, 32'hFF00_ED34);
    issue(4'd5, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    check("slt_result", result, 32'h1);
    issue(4'd10, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    check("sltu_result", result, 32'h0);
    issue(4'd9, 32'h8000_0000, 32'h1, 32'h24, 1'b1);
    check("sra_imm_result", result, 32'hF800_0000);
    issue(4'd7, 32'h1, 32'd31, 32'h0, 1'b0);
    check("sll_result", result, 32'h8000_0000);
    issue(4'd8, 32'h8000_0000, 32'd31, 32'h0, 1'b0);
    check("srl_result", result, 32'h1);

    // NONE and reserved clear the result but still pulse
    issue(4'd6, 32'h1234, 32'h1, 32'h0, 1'b0);
    check("none_result", result, 32'h0);
    check("none_ov", out_valid, 1);
    issue(4'd0, 32'd100, 32'd23, 32'h0, 1'b0);
    check("add_123", result, 32'd123);
    issue(4'd13, 32'h55, 32'h1, 32'h0, 1'b0);
    check("reserved_result", result, 32'h0);
    check("reserved_ov", out_valid, 1);

    // flush in IDLE suppresses acceptance
    issue(4'd0, 32'd100, 32'd23, 32'h0, 1'b0);
    flush = 1'b1;
    issue(4'd0, 32'd2, 32'd3, 32'h0, 1'b0);
    flush = 1'b0;
    check("idle_flush_ov", out_valid, 0);
    check("idle_flush_result", result, 32'd123);
    step();
    check("hold_result", result, 32'd123);
    check("hold_ov", out_valid, 0);

`ifdef EX_ALU_MUL_EN
    // MUL 7x6: 32 BUSY cycles, then result with a pulse
    issue(4'd11, 32'd7, 32'd6, 32'h0, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      check($sformatf("mul_busy_ready_c%0d", i), in_ready, 0);
      check($sformatf("mul_busy_ov_c%0d", i), out_valid, 0);
      step();
    end
    check("mul_7x6_result", result, 32'd42);
    check("mul_7x6_ov", out_valid, 1);
    check("mul_7x6_ready", in_ready, 1);

    // back-to-back MUL on the cycle in_ready returns
    issue(4'd11, 32'h1_0000, 32'h1_0000, 32'h0, 1'b0);
    for (int i = 1; i <= 32; i++) step();
    check("mul_ovf_result", result, 32'h0);
    check("mul_ovf_ov", out_valid, 1);

    // requests while BUSY ignored; flush on cycle 10
    issue(4'd0, 32'd100, 32'd23, 32'h0, 1'b0);
    check("pre_flush_result", result, 32'd123);
    issue(4'd11, 32'd3, 32'd5, 32'h0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      if (i <= 5) begin
        aluop = 4'd0; op_a = 32'd1; op_b = 32'd1; alusrc = 1'b0;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      check($sformatf("busy_ignore_ready_c%0d", i), in_ready, 0);
      check($sformatf("busy_ignore_ov_c%0d", i), out_valid, 0);
    end
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("busy_flush_ready", in_ready, 1);
    check("busy_flush_ov", out_valid, 0);
    check("busy_flush_result", result, 32'd123);
    seen_ov = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen_ov = 1'b1;
    end
    check("busy_flush_no_late_ov", seen_ov, 0);

    // flush during the final iteration wins
    issue(4'd11, 32'd2, 32'd3, 32'h0, 1'b0);
    for (int i = 1; i <= 31; i++) step();
    check("last_iter_ready", in_ready, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("last_flush_ov", out_valid, 0);
    check("last_flush_result", result, 32'd123);
    check("last_flush_ready", in_ready, 1);

    // asynchronous reset mid-MUL
    issue(4'd11, 32'd9, 32'd9, 32'h0, 1'b0);
    step(); step(); step();
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_result", result, 32'h0);
    check("async_rst_ready", in_ready, 1);
    check("async_rst_zero", zero, 1);
    #2;
    reset = 1'b0;
    seen_ov = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen_ov = 1'b1;
    end
    check("async_rst_no_ov", seen_ov, 0);
    check("async_rst_result_held", result, 32'h0);
`else
    // aluop 11 without the multiplier: reserved, latency 1, never stalls
    check("nomul_pre_result", result, 32'd123);
    issue(4'd11, 32'd3, 32'd4, 32'h0, 1'b0);
    check("nomul_result", result, 32'h0);
    check("nomul_ov", out_valid, 1);
    check("nomul_ready", in_ready, 1);
    step();
    check("nomul_ov_drop", out_valid, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_alu_mc.md
EX_ALU_MC -- requirements
Module: ex_alu_mc

Interface
REQ-001 Parameter XLEN, default 32, operand/result width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter MUL_STEPS, default 1, multiplier bits retired per iteration; legal values 1, 2, 4; XLEN divisible by MUL_STEPS.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operation request qualifier.
REQ-006 in_ready  output  1  unit accepts a request this cycle.
REQ-007 op_a  input  XLEN  operand 1.
REQ-008 op_b  input  XLEN  register operand 2.
REQ-009 imme  input  XLEN  immediate operand.
REQ-010 alusrc  input  1  1 selects imme as operand 2, 0 selects op_b.
REQ-011 aluop  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 NONE, 7 SLL, 8 SRL, 9 SRA, 10 SLTU, 11 MUL; 12-15 reserved.
REQ-012 flush  input  1  abort any in-flight operation.
REQ-013 out_valid  output  1  one-cycle pulse, result registered this cycle.
REQ-014 result  output  XLEN  last completed result, held between completions.
REQ-015 zero  output  1  result == 0, combinational from result register.

Function
REQ-016 Handshake: request accepted on a rising edge when in_valid && in_ready; operands and aluop captured at acceptance only.
REQ-017 States IDLE and BUSY; in_ready = 1 in IDLE, 0 in BUSY.
REQ-018 Ops 0-10 and 12-15: IDLE -> IDLE; result updated and out_valid = 1 on the cycle after acceptance (latency 1).
REQ-019 ADD/SUB: modulo 2^XLEN; AND/OR/XOR: bitwise.
REQ-020 SLT: result 1 if signed op_a < signed op2, else 0; SLTU: same, unsigned.
REQ-021 SLL/SRL/SRA: shift amount = low log2(XLEN) bits of op2; SRA sign-fills.
REQ-022 NONE and reserved codes: result 0, out_valid still pulses.
REQ-023 MUL: IDLE -> BUSY at acceptance; iterative shift-add retiring MUL_STEPS multiplier bits per cycle; XLEN/MUL_STEPS cycles in BUSY; on the last BUSY cycle BUSY -> IDLE, result = low XLEN bits of the product, out_valid = 1.
REQ-024 MUL total latency XLEN/MUL_STEPS cycles from acceptance edge to the out_valid cycle; back-to-back MUL possible on the cycle in_ready returns to 1.
REQ-025 in_valid while BUSY: ignored, not queued.
REQ-026 flush in IDLE: any acceptance in that cycle is suppressed; no out_valid next cycle.
REQ-027 flush in BUSY: next state IDLE, partial product discarded, result unchanged, no out_valid.
REQ-028 flush and final MUL iteration in the same cycle: flush wins, no out_valid, result unchanged.
REQ-029 result and zero unchanged on cycles with out_valid = 0.

Reset
REQ-030 reset asserted: state IDLE, result 0, out_valid 0, zero 1, in_ready 1, multiplier registers 0, independent of clk.
REQ-031 reset mid-MUL: operation discarded, no out_valid after deassertion.
REQ-032 First acceptance possible on the first rising edge after reset deassertion.

Configuration
REQ-033 Macro EX_ALU_MUL_EN defined: MUL (aluop 11) implemented per REQ-023 to REQ-028.
REQ-034 Macro EX_ALU_MUL_EN undefined: no multiplier logic and no BUSY state; aluop 11 treated as reserved (result 0, latency 1); in_ready tied 1.

Verification
REQ-035 XLEN=32: ADD 0xFFFFFFFF + 1 -> next cycle result 0x00000000, zero 1, out_valid 1 for exactly one cycle.
REQ-036 SLT -1 vs 1 -> result 1; SLTU 0xFFFFFFFF vs 1 -> result 0; SRA 0x80000000 by imme 0x24 (alusrc 1) -> result 0xF8000000.
REQ-037 MUL_EN, MUL_STEPS=1: MUL 7 x 6 -> in_ready 0 for 32 cycles, result 42 with out_valid on the 32nd cycle after acceptance; MUL 0x10000 x 0x10000 -> 0.
REQ-038 MUL in progress, in_valid ADD presented for 5 cycles -> ignored; flush on cycle 10 -> in_ready 1 next cycle, no out_valid, result keeps prior value.
REQ-039 reset asserted asynchronously mid-MUL between clock edges -> result 0 and in_ready 1 immediately; no out_valid after deassertion.
REQ-040 EX_ALU_MUL_EN undefined: aluop 11 with 3 x 4 -> result 0, latency 1, in_ready stays 1.
